// File: rtl/serial_frame_tx_pkg.sv
// Shared link constants and transmitter state type. The link receiver imports the
// same preamble definition, so SYNC_WORD/SYNC_BITS must only change here.
package serial_frame_tx_pkg;

    localparam int unsigned ENC_DATA_BITS = 216;
    localparam int unsigned DATA_BITS     = ENC_DATA_BITS;
    localparam int unsigned SYNC_BITS     = 8;
    localparam logic [SYNC_BITS-1:0] SYNC_WORD = 8'b1010_1011;
    localparam int unsigned GAP_CYCLES    = 4;
    localparam int unsigned FRAME_CYCLES  = SYNC_BITS + DATA_BITS + GAP_CYCLES;

    // One down-counter serves every state; DATA_BITS is the largest reload value.
    localparam int unsigned CNT_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StData,
        StGap
    } tx_state_t;

endpackage

// File: rtl/serial_frame_tx_buffer.sv
// Single-entry pending buffer ahead of the transmit shift register.
// tx_ready upstream is simply !pend_valid, so readiness never depends on tx_valid.
module serial_frame_tx_buffer
    import serial_frame_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic                 pend_valid,
    output logic [DATA_BITS-1:0] pend_data
);

    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q;

    // Occupancy: push only happens while empty and pop only while full.
    always_comb begin
        valid_d = valid_q;
        if (push) begin
            valid_d = 1'b1;
        end
        if (pop) begin
            valid_d = 1'b0;
        end
    end

    // Occupancy flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data register; contents are ignored while valid_q is low, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q <= push_data;
        end
    end

    assign pend_valid = valid_q;
    assign pend_data  = data_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Serial link transmitter: frames each payload word as preamble, payload MSB first,
// then a fixed idle-low gap, one bit per clock on a registered output.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Preamble and payload share one shift register so SYNC and DATA shift identically.
    localparam int unsigned ShiftW = SYNC_BITS + DATA_BITS;

    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ShiftW-1:0]    shift_q, shift_d;
    logic                 serial_q, serial_d;

    logic                 pend_valid;
    logic [DATA_BITS-1:0] pend_data;
    logic                 accept, push, pop, load, load_direct, cnt_last;
    logic [DATA_BITS-1:0] load_data;
    logic [ShiftW-1:0]    load_word;

    assign tx_ready  = ~pend_valid;
    assign accept    = tx_valid & tx_ready;
    assign cnt_last  = (cnt_q == CNT_W'(1));
    assign push      = accept & ~load_direct;
    // At the end of a gap a queued word has priority; otherwise take the input directly.
    assign load_data = ((state_q == StGap) && pend_valid) ? pend_data : tx_data;
    assign load_word = {SYNC_WORD, load_data};

    serial_frame_tx_buffer u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (tx_data),
        .pop        (pop),
        .pend_valid (pend_valid),
        .pend_data  (pend_data)
    );

    // Next state, counter, shift register and next line bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        serial_d    = serial_q;
        pop         = 1'b0;
        load        = 1'b0;
        load_direct = 1'b0;

        case (state_q)
            StIdle: begin
                serial_d = 1'b0;
                if (accept) begin
                    load        = 1'b1;
                    load_direct = 1'b1;
                end
            end
            StSync: begin
                cnt_d    = cnt_q - CNT_W'(1);
                serial_d = shift_q[ShiftW-1];
                shift_d  = {shift_q[ShiftW-2:0], 1'b0};
                if (cnt_last) begin
                    state_d = StData;
                    cnt_d   = CNT_W'(DATA_BITS);
                end
            end
            StData: begin
                cnt_d    = cnt_q - CNT_W'(1);
                serial_d = shift_q[ShiftW-1];
                shift_d  = {shift_q[ShiftW-2:0], 1'b0};
                if (cnt_last) begin
                    state_d  = StGap;
                    cnt_d    = CNT_W'(GAP_CYCLES);
                    serial_d = 1'b0;
                end
            end
            StGap: begin
                serial_d = 1'b0;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_last) begin
                    if (pend_valid) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else if (accept) begin
                        // Word arriving in the final gap cycle goes straight out: no extra idle.
                        load        = 1'b1;
                        load_direct = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                serial_d = 1'b0;
            end
        endcase

        // Frame start: first preamble bit goes on the line at this edge.
        if (load) begin
            state_d  = StSync;
            cnt_d    = CNT_W'(SYNC_BITS);
            serial_d = load_word[ShiftW-1];
            shift_d  = {load_word[ShiftW-2:0], 1'b0};
        end
    end

    // Control state and line register; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            serial_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
        end
    end

    // Datapath shift register; only read after a load, so no reset needed.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign serial_out = serial_q;
    assign tx_busy    = (state_q != StIdle);
    assign tx_done    = (state_q == StData) && cnt_last;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed cycle checks plus a receiver model that
// deframes serial_out and compares each word against a queue of sent words.
module tb_serial_frame_tx;

    localparam int DB = 216;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic [DB-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, serial_out, tx_busy, tx_done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DB-1:0] exp_q[$];

    // Receiver model state
    int            rx_count   = 0;
    logic          rx_hunting = 1'b1;
    logic [7:0]    rx_win     = '0;
    logic [DB-1:0] rx_word    = '0;
    int            rx_bits    = 0;
    logic [DB-1:0] rx_exp;

    always #5 clk = ~clk;

    serial_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected line bit in the rel-th cycle after the accept cycle of word d.
    function automatic logic exp_bit(input int rel, input logic [DB-1:0] d);
        logic [7:0] sw;
        sw = 8'b1010_1011;
        if (rel >= 1 && rel <= 8) return sw[3'(8 - rel)];
        if (rel >= 9 && rel <= 224) return d[8'(224 - rel)];
        return 1'b0;
    endfunction

    function automatic logic [DB-1:0] rand_word();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[32*i +: 32] = $urandom;
        return r[DB-1:0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tx_valid = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Present d until accepted; returns in the cycle after the accept cycle.
    task automatic send_word(input logic [DB-1:0] d, output int waited);
        tx_valid = 1'b1;
        tx_data  = d;
        for (int w = 0; w < 1000; w++) begin
            if (tx_ready === 1'b1) begin
                exp_q.push_back(d);
                waited = w;
                next_cycle();
                tx_valid = 1'b0;
                tx_data  = ~d;
                return;
            end
            next_cycle();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: tx_ready never rose, expected acceptance within 1000 cycles");
        tx_valid = 1'b0;
        waited   = -1;
    endtask

    task automatic wait_rx(input int target, input int budget);
        for (int w = 0; w < budget; w++) begin
            if (rx_count >= target) return;
            next_cycle();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL rx_timeout: rx_count %0d expected %0d", rx_count, target);
    endtask

    // Monitor: link receiver model; hunts for the preamble, collects the payload, compares.
    always @(negedge clk) begin
        if (rst) begin
            rx_hunting = 1'b1;
            rx_win     = '0;
            rx_bits    = 0;
        end else if (rx_hunting) begin
            rx_win = {rx_win[6:0], serial_out};
            if (rx_win == 8'b1010_1011) begin
                rx_hunting = 1'b0;
                rx_bits    = 0;
            end
        end else begin
            rx_word = {rx_word[DB-2:0], serial_out};
            rx_bits++;
            if (rx_bits == DB) begin
                rx_hunting = 1'b1;
                rx_win     = '0;
                rx_count++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_word: received %h but no word was expected", rx_word);
                end else begin
                    rx_exp = exp_q.pop_front();
                    if (rx_word !== rx_exp) begin
                        n_fail++;
                        $display("FAIL rx_word: got %h expected %h", rx_word, rx_exp);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] w0, w1, w2;
        int            waited, base, gap;

        // Single frame and reset state
        do_reset();
        chk1("rst_serial", serial_out, 1'b0);
        chk1("rst_busy", tx_busy, 1'b0);
        chk1("rst_done", tx_done, 1'b0);
        chk1("rst_ready", tx_ready, 1'b1);
        w0 = {108{2'b10}};
        base = rx_count;
        send_word(w0, waited);
        for (int k = 1; k <= 229; k++) begin
            chk1("t1_serial", serial_out, exp_bit(k, w0));
            chk1("t1_done", tx_done, k == 224);
            chk1("t1_busy", tx_busy, k <= 228);
            next_cycle();
        end
        wait_rx(base + 1, 100);
        chkn("t1_rx_count", rx_count - base, 1);

        // Back-to-back: W0 at cycle 0, W1 at cycle 1
        do_reset();
        w0 = '1;
        w1 = '0;
        base = rx_count;
        send_word(w0, waited);
        chk1("t2_ready_c1", tx_ready, 1'b1);
        send_word(w1, waited);
        for (int k = 2; k <= 460; k++) begin
            chk1("t2_serial", serial_out, exp_bit(k, w0) | exp_bit(k - 228, w1));
            chk1("t2_done", tx_done, (k == 224) || (k == 452));
            chk1("t2_busy", tx_busy, k <= 456);
            if (k <= 228) chk1("t2_ready", tx_ready, 1'b0);
            next_cycle();
        end
        wait_rx(base + 2, 100);
        chkn("t2_rx_count", rx_count - base, 2);

        // Backpressure: third word held while pending is full
        do_reset();
        base = rx_count;
        send_word(rand_word(), waited);
        send_word(rand_word(), waited);
        send_word(rand_word(), waited);
        chkn("t3_accept_wait", waited, 227);
        wait_rx(base + 3, 1200);
        repeat (300) next_cycle();
        chkn("t3_rx_count", rx_count - base, 3);
        chkn("t3_queue_empty", exp_q.size(), 0);

        // Accept in the final gap cycle starts the next preamble immediately
        do_reset();
        base = rx_count;
        w0 = rand_word();
        w1 = rand_word();
        send_word(w0, waited);
        repeat (227) next_cycle();
        chk1("t6_busy_gap", tx_busy, 1'b1);
        chk1("t6_ready_gap", tx_ready, 1'b1);
        send_word(w1, waited);
        for (int k = 229; k <= 240; k++) begin
            chk1("t6_serial", serial_out, exp_bit(k - 228, w1));
            chk1("t6_busy", tx_busy, 1'b1);
            next_cycle();
        end
        wait_rx(base + 2, 500);
        chkn("t6_rx_count", rx_count - base, 2);

        // Reset mid-frame at cycle 100
        do_reset();
        w0 = rand_word();
        w1 = rand_word();
        send_word(w0, waited);
        repeat (99) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_q.delete();
        base = rx_count;
        for (int k = 101; k <= 104; k++) begin
            chk1("t4_serial", serial_out, 1'b0);
            chk1("t4_busy", tx_busy, 1'b0);
            chk1("t4_ready", tx_ready, 1'b1);
            chk1("t4_done", tx_done, 1'b0);
            next_cycle();
        end
        send_word(w1, waited);
        for (int k = 106; k <= 335; k++) begin
            chk1("t4_serial_new", serial_out, exp_bit(k - 105, w1));
            chk1("t4_done_new", tx_done, k == 329);
            chk1("t4_busy_new", tx_busy, (k - 105) <= 228);
            next_cycle();
        end
        wait_rx(base + 1, 100);
        chkn("t4_rx_count", rx_count - base, 1);

        // Loopback: 50 random words with random gaps
        do_reset();
        base = rx_count;
        for (int i = 0; i < 50; i++) begin
            gap = int'($urandom_range(0, 250));
            repeat (gap) next_cycle();
            send_word(rand_word(), waited);
        end
        wait_rx(base + 50, 1000);
        chkn("t5_rx_count", rx_count - base, 50);
        chkn("t5_queue_empty", exp_q.size(), 0);

        // Idle integrity
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            chk1("t7_serial", serial_out, 1'b0);
            chk1("t7_busy", tx_busy, 1'b0);
            chk1("t7_done", tx_done, 1'b0);
            chk1("t7_ready", tx_ready, 1'b1);
            next_cycle();
        end

        chkn("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
